// File: rtl/flyer_swarm_ctrl.sv
// N-channel airborne enemy mover: spawn/fly/cooldown per channel, fixed-point motion with bounce and random reversal.
// Optional build macro SWARM_STAGGER_EN: channel i parks at START_Y + i*STAGGER_Y instead of START_Y.
module flyer_swarm_ctrl #(
    parameter int N_FLYERS        = 4,
    parameter int FRAC_BITS       = 6,
    parameter int X_SPEED         = -120,
    parameter int Y_SPEED         = 70,
    parameter int START_X         = 680,
    parameter int START_Y         = 60,
    parameter int STAGGER_Y       = 40,
    parameter int Y_MIN           = 20,
    parameter int Y_MAX           = 180,
    parameter int EXIT_X          = -50,
    parameter int SPAWN_LO        = 500,
    parameter int SPAWN_HI        = 605,
    parameter int FLIP_LO         = 300,
    parameter int FLIP_HI         = 600,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    pause,
    input  logic [10:0]             RNG,
    input  logic [N_FLYERS-1:0]     hit,
    output logic [N_FLYERS*11-1:0]  topLeftX,
    output logic [N_FLYERS*11-1:0]  topLeftY,
    output logic [N_FLYERS-1:0]     active,
    output logic [3:0]              activeCount
);

    localparam int PW = 11 + FRAC_BITS;
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
`ifdef SWARM_STAGGER_EN
    localparam int STAGGER_STEP = STAGGER_Y;
`else
    localparam int STAGGER_STEP = 0;
`endif

    localparam logic signed [PW-1:0] PARK_X  = PW'(START_X * (2 ** FRAC_BITS));
    localparam logic signed [PW-1:0] X_STEP  = PW'(X_SPEED);
    localparam logic signed [15:0]   VY_UP   = 16'(Y_SPEED);
    localparam logic signed [15:0]   VY_DN   = 16'(-Y_SPEED);
    localparam logic signed [10:0]   YMIN_PX = 11'(Y_MIN);
    localparam logic signed [10:0]   YMAX_PX = 11'(Y_MAX);
    localparam logic signed [10:0]   EXIT_PX = 11'(EXIT_X);
    localparam logic [CW-1:0]        CD_LOAD = CW'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

    function automatic logic [11:0] offset(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'd6;
            3'd1:    return 12'd501;
            3'd2:    return 12'd80;
            3'd3:    return 12'd100;
            3'd4:    return 12'd140;
            3'd5:    return 12'd18;
            3'd6:    return 12'd44;
            default: return 12'd340;
        endcase
    endfunction

    function automatic logic [11:0] sample(input logic [10:0] rnd, input logic [2:0] idx);
        return {1'b0, rnd} + offset(idx);
    endfunction

    function automatic logic in_window(input logic [11:0] s, input int lo, input int hi);
        return (int'(s) >= lo) && (int'(s) < hi);
    endfunction

    function automatic logic signed [PW-1:0] park_y(input int ch);
        return PW'((START_Y + ch * STAGGER_STEP) * (2 ** FRAC_BITS));
    endfunction

    // Pixel coordinate is the integer part of the fixed-point position (floor).
    function automatic logic signed [10:0] pixel(input logic signed [PW-1:0] p);
        return p[PW-1:FRAC_BITS];
    endfunction

    state_t                st_q  [N_FLYERS];
    state_t                st_d  [N_FLYERS];
    logic signed [PW-1:0]  x_q   [N_FLYERS];
    logic signed [PW-1:0]  x_d   [N_FLYERS];
    logic signed [PW-1:0]  y_q   [N_FLYERS];
    logic signed [PW-1:0]  y_d   [N_FLYERS];
    logic signed [15:0]    vy_q  [N_FLYERS];
    logic signed [15:0]    vy_d  [N_FLYERS];
    logic [CW-1:0]         cnt_q [N_FLYERS];
    logic [CW-1:0]         cnt_d [N_FLYERS];
    logic [2:0]            frame_idx;
    logic                  frame_go;
    logic                  spawn_ok;
    logic                  spawned;
    logic signed [15:0]    vy_new;
    logic signed [PW-1:0]  x_new;
    logic [3:0]            count_d;

    always_comb begin
        frame_go = startOfFrame && !pause;
        spawn_ok = frame_go && in_window(sample(RNG, frame_idx), SPAWN_LO, SPAWN_HI);
        spawned  = 1'b0;
        vy_new   = '0;
        x_new    = '0;
        count_d  = '0;
        for (int i = 0; i < N_FLYERS; i++) begin
            st_d[i]  = st_q[i];
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            vy_d[i]  = vy_q[i];
            cnt_d[i] = cnt_q[i];
            case (st_q[i])
                IDLE: begin
                    x_d[i]  = PARK_X;
                    y_d[i]  = park_y(i);
                    vy_d[i] = VY_UP;
                    if (spawn_ok && !spawned) begin
                        st_d[i] = FLY;
                        spawned = 1'b1;
                    end
                end
                FLY: begin
                    if (hit[i]) begin
                        st_d[i]  = COOLDOWN;
                        cnt_d[i] = CD_LOAD;
                    end else if (frame_go) begin
                        if (pixel(y_q[i]) < YMIN_PX)
                            vy_new = VY_UP;
                        else if (pixel(y_q[i]) > YMAX_PX)
                            vy_new = VY_DN;
                        else if (in_window(sample(RNG, frame_idx + 3'(i)), FLIP_LO, FLIP_HI))
                            vy_new = -vy_q[i];
                        else
                            vy_new = vy_q[i];
                        x_new   = x_q[i] + X_STEP;
                        x_d[i]  = x_new;
                        y_d[i]  = y_q[i] + PW'(vy_new);
                        vy_d[i] = vy_new;
                        if (pixel(x_new) <= EXIT_PX) begin
                            st_d[i]  = COOLDOWN;
                            cnt_d[i] = CD_LOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    if (frame_go) begin
                        if (cnt_q[i] <= CW'(1)) begin
                            st_d[i]  = IDLE;
                            cnt_d[i] = '0;
                            x_d[i]   = PARK_X;
                            y_d[i]   = park_y(i);
                            vy_d[i]  = VY_UP;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CW'(1);
                        end
                    end
                end
                default: st_d[i] = IDLE;
            endcase
            count_d = count_d + 4'(st_d[i] == FLY);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_idx   <= '0;
            activeCount <= '0;
            for (int i = 0; i < N_FLYERS; i++) begin
                st_q[i]  <= IDLE;
                x_q[i]   <= PARK_X;
                y_q[i]   <= park_y(i);
                vy_q[i]  <= VY_UP;
                cnt_q[i] <= '0;
            end
        end else begin
            if (startOfFrame)
                frame_idx <= frame_idx + 3'd1;
            activeCount <= count_d;
            for (int i = 0; i < N_FLYERS; i++) begin
                st_q[i]  <= st_d[i];
                x_q[i]   <= x_d[i];
                y_q[i]   <= y_d[i];
                vy_q[i]  <= vy_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Positions only change on FLY updates and reparks, so COOLDOWN holds the last pixels.
    for (genvar g = 0; g < N_FLYERS; g++) begin : g_out
        assign topLeftX[11*g +: 11] = pixel(x_q[g]);
        assign topLeftY[11*g +: 11] = pixel(y_q[g]);
        assign active[g]            = (st_q[g] == FLY);
    end

endmodule

// File: tb/tb_flyer_swarm_ctrl.sv
// Directed bench for flyer_swarm_ctrl: reset, spawn/motion, bounce/exit/cooldown, hit arbitration, pause, flip.
module tb_flyer_swarm_ctrl;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        pause;
    logic [10:0] RNG;
    logic [3:0]  hit;
    logic [43:0] topLeftX;
    logic [43:0] topLeftY;
    logic [3:0]  active;
    logic [3:0]  activeCount;

    int nvec = 0;
    int nmis = 0;
    int fi   = 0;
    int off [8] = '{6, 501, 80, 100, 140, 18, 44, 340};

    always #5 clk = ~clk;

    flyer_swarm_ctrl dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .pause        (pause),
        .RNG          (RNG),
        .hit          (hit),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .active       (active),
        .activeCount  (activeCount)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int xo(input int i);
        return int'($signed(topLeftX[11*i +: 11]));
    endfunction

    function automatic int yo(input int i);
        return int'($signed(topLeftY[11*i +: 11]));
    endfunction

    function automatic int start_y(input int i);
`ifdef SWARM_STAGGER_EN
        return 60 + 40 * i;
`else
        return 60 + 0 * i;
`endif
    endfunction

    task automatic tick(input int rng_v);
        @(negedge clk);
        RNG = 11'(rng_v);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        fi = (fi + 1) % 8;
    endtask

    task automatic frames(input int n, input int rng_v);
        for (int k = 0; k < n; k++) tick(rng_v);
    endtask

    // Spawn sample lands on 520 whatever the current frame index is.
    task automatic spawn_tick();
        tick(520 - off[fi]);
    endtask

    task automatic pulse_hit(input logic [3:0] v);
        @(negedge clk);
        hit = v;
        @(negedge clk);
        hit = 4'b0000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; pause = 1'b0; RNG = '0; hit = '0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_x%0d", i), xo(i), 680);
            chk($sformatf("rst_y%0d", i), yo(i), start_y(i));
        end
        chk("rst_active", active, 0);
        chk("rst_count", activeCount, 0);

        // Spawn at frame index 0 (sample 506), then straight flight.
        tick(500);
        chk("spawn_active", active, 4'b0001);
        chk("spawn_count", activeCount, 1);
        chk("spawn_x", xo(0), 680);
        chk("spawn_y", yo(0), 60);
        tick(1000);
        chk("f1_x", xo(0), 678);
        chk("f1_y", yo(0), 61);
        tick(1000);
        chk("f2_x", xo(0), 676);
        chk("f2_y", yo(0), 62);
        frames(109, 1000);
        chk("f111_x", xo(0), 471);
        chk("f111_y", yo(0), 181);
        tick(1000);
        chk("f112_x", xo(0), 470);
        chk("f112_y", yo(0), 180);
        tick(1000);
        chk("f113_x", xo(0), 468);
        chk("f113_y", yo(0), 179);
        frames(275, 1000);
        chk("f388_active", active, 4'b0001);
        chk("f388_x", xo(0), -48);
        tick(1000);
        chk("exit_active", active, 0);
        chk("exit_count", activeCount, 0);
        chk("exit_x", xo(0), -50);
        frames(29, 1000);
        chk("cd29_active", active, 0);
        chk("cd29_x", xo(0), -50);
        tick(1000);
        chk("repark_x", xo(0), 680);
        chk("repark_y", yo(0), start_y(0));
        chk("repark_active", active, 0);

        // Arbitration and hits.
        spawn_tick();
        chk("arb_active", active, 4'b0001);
        chk("arb_count", activeCount, 1);
        pulse_hit(4'b0010);
        chk("hit_idle_ignored", active, 4'b0001);
        pulse_hit(4'b0001);
        chk("hit_active", active, 0);
        chk("hit_count", activeCount, 0);
        spawn_tick();
        chk("cd_block1", active, 4'b0010);
        frames(28, 1000);
        chk("cd_block29", active, 4'b0010);
        spawn_tick();
        chk("cd_expire_spawn", active, 4'b0110);
        chk("cd_expire_count", activeCount, 2);
        spawn_tick();
        chk("respawn_active", active, 4'b0111);
        chk("respawn_count", activeCount, 3);
        chk("ch2_moved_x", xo(2), 678);
        pulse_hit(4'b0100);
        chk("hit2_active", active, 4'b0011);
        chk("hit2_hold_x", xo(2), 678);

        // Pause: spawn samples in window, yet nothing moves or spawns.
        pause = 1'b1;
        for (int k = 0; k < 10; k++) spawn_tick();
        pause = 1'b0;
        chk("pause_active", active, 4'b0011);
        chk("pause_count", activeCount, 2);
        chk("pause_x0", xo(0), 680);
        chk("pause_y0", yo(0), start_y(0));
        frames(29, 1000);
        chk("pause_cd_x2", xo(2), 678);
        chk("pause_cd_active", active, 4'b0011);
        tick(1000);
        chk("pause_repark_x2", xo(2), 680);
        chk("pause_repark_y2", yo(2), start_y(2));

        // Asynchronous reset mid-flight.
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        chk("mid_rst_x0", xo(0), 680);
        chk("mid_rst_y1", yo(1), start_y(1));
        chk("mid_rst_active", active, 0);
        chk("mid_rst_count", activeCount, 0);
        @(negedge clk);
        resetN = 1'b1;
        fi = 0;

        // Flip: channel 0 sample 450 negates vy, sample 600 does not.
        tick(500);
        chk("flip_spawn", active, 4'b0001);
        tick(1000);
        chk("flip_pre_y", yo(0), 61);
        tick(370);
        chk("flip_y", yo(0), 60);
        chk("flip_x", xo(0), 676);
        tick(1000);
        chk("flip_hold_y", yo(0), 58);
        tick(460);
        chk("noflip_y", yo(0), 57);
        chk("noflip_spawn", active, 4'b0011);
        chk("noflip_count", activeCount, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/flyer_swarm_ctrl.md
# flyer_swarm_ctrl

Multi-channel motion controller for airborne enemies: up to N independent flyers, each with a spawn/fly/cooldown life cycle, fixed-point position integration, vertical bounce and random vertical reversal. It sits between the frame-timing/RNG logic and the per-object draw and collision blocks. It replaces single-flyer movers: one instance drives N sprites, with hit-kill and per-channel status outputs.

## Interface
Parameters:
- N_FLYERS, 4, number of channels (1..8)
- FRAC_BITS, 6, fixed-point fraction bits
- X_SPEED, -120, horizontal velocity, fixed-point units per frame
- Y_SPEED, 70, vertical speed magnitude, fixed-point units per frame
- START_X, 680, parked/spawn X, pixels
- START_Y, 60, parked/spawn Y, pixels
- STAGGER_Y, 40, per-channel Y offset, pixels; used only with SWARM_STAGGER_EN
- Y_MIN, 20, top bounce limit, pixels
- Y_MAX, 180, bottom bounce limit, pixels
- EXIT_X, -50, leave-screen threshold, pixels
- SPAWN_LO, 500, spawn window low bound (inclusive)
- SPAWN_HI, 605, spawn window high bound (exclusive)
- FLIP_LO, 300, reversal window low bound (inclusive)
- FLIP_HI, 600, reversal window high bound (exclusive)
- COOLDOWN_FRAMES, 30, frames spent in COOLDOWN

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle frame tick
- pause  in  1  freeze motion, spawning and cooldown
- RNG  in  11  free-running random value
- hit  in  N_FLYERS  per-channel kill pulse
- topLeftX  out  N_FLYERS*11  signed pixel X, channel i at bits [11i+10:11i]
- topLeftY  out  N_FLYERS*11  signed pixel Y, same packing
- active  out  N_FLYERS  channel i is in FLY
- activeCount  out  4  number of channels in FLY

## Operation
- Per-channel state: IDLE, FLY, COOLDOWN. Positions are signed (11+FRAC_BITS)-bit registers; pixel outputs are position arithmetically shifted right by FRAC_BITS. Velocity vy is a signed 16-bit register.
- Offset table (8 entries, index 0..7): 6, 501, 80, 100, 140, 18, 44, 340. frameIdx is a 3-bit counter that advances on every startOfFrame, wraps 7->0 and is not affected by pause.
- Samples are 12-bit unsigned with no overflow. The spawn sample is RNG + off[frameIdx]. The channel i sample is RNG + off[(frameIdx+i) mod 8].
- IDLE: position is held at (START_X, start Y of channel), vy = +Y_SPEED. On a frame where pause=0 and the spawn sample is in [SPAWN_LO, SPAWN_HI), the lowest-index IDLE channel enters FLY. At most one spawn occurs per frame.
- FLY, on a frame with pause=0, evaluated in priority order:
  - If Y < Y_MIN, vy = +Y_SPEED.
  - Else if Y > Y_MAX, vy = -Y_SPEED.
  - Else if the channel sample is in [FLIP_LO, FLIP_HI), vy = -vy.
  - Then X += X_SPEED and Y += new vy, in the same frame.
  - If the updated pixel X <= EXIT_X, the channel enters COOLDOWN.
- FLY with pause=1: position and vy are held.
- hit[i] is sampled every clk. In FLY it forces COOLDOWN on the next clk edge and takes priority over a same-cycle frame update. In IDLE or COOLDOWN it is ignored.
- COOLDOWN: on entry, a counter loads COOLDOWN_FRAMES. It decrements on each unpaused frame. When it reaches 0, the channel enters IDLE and its position is reparked in the same edge. The channel's topLeftX/Y hold their last values during COOLDOWN.
- Reset: all channels IDLE at the parked position, vy = +Y_SPEED, counters 0, frameIdx 0, active=0, activeCount=0.

## Timing
- All state changes occur on the clk edge where startOfFrame=1, except hit handling. All outputs are registered.
- Spawn: active[i] rises one clk after the spawning frame tick. Motion starts on the following frame.
- Hit: active[i] falls one clk after hit[i] is seen.
- activeCount is registered and is valid in the same cycle as active.
- Reset asserted mid-flight immediately returns every output to its reset value.
- When pause and startOfFrame coincide, only frameIdx advances.

## Configuration
- SWARM_STAGGER_EN defined: channel i start Y = START_Y + i*STAGGER_Y, applied at reset and on every repark.
- SWARM_STAGGER_EN undefined: all channels use START_Y. Only the parked Y differs between the two builds; all other behaviour is identical.

## Test plan
- Reset with N_FLYERS=4: every topLeftX=680, every topLeftY=60 (stagger build: 60, 100, 140, 180), active=0, activeCount=0.
- Spawn: RNG=500 at frameIdx 0 (sample 506) -> active=0001 and activeCount=1; then RNG=1000 (no flips, no spawn) -> X decreases 120/64 px per frame, Y increases 70/64 px per frame.
- Bounce and exit: hold RNG=1000 -> Y rises past 180, then vy flips to -70; when X <= -50 -> COOLDOWN, then after 30 frames IDLE with X reparked at 680.
- Hit and arbitration: channels 0 and 1 IDLE with a spawn sample in window -> only channel 0 spawns. Pulse hit=0001 mid-flight -> active[0] falls after 1 clk and re-spawn is blocked for 30 frames. hit=0010 while channel 1 is IDLE -> ignored.
- Pause: pause=1 for 10 frames in FLY -> topLeftX/Y and the COOLDOWN counter are frozen and there are no spawns, while frameIdx still advances by 10.
- Flip: with Y in range, RNG set so the channel sample is 450 -> vy is negated once that frame; sample 600 -> no flip.
